upl_fifo_tx_reader: RTL

Read side of the upload FIFO. On each packet request from the upload writer (tx_data_en/tx_data_len), it reads ceil(len/4) 32-bit words from the upload FIFO. It serializes them big-endian into a byte stream with valid/ready handshake toward the UDP transmit engine, then pulses send_finish. Sits between the upload FIFO read port and the UDP/MAC transmit path.

---
 rtl/eth_upl_pkg.sv | 28 ++
 rtl/upl_word_serializer.sv | 41 ++++
 rtl/upl_fifo_tx_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_upl_pkg.sv
// Shared constants for the upload FIFO transmit path: FSM encoding,
// payload limits, word geometry and byte order.
package eth_upl_pkg;

    localparam int MAX_LEN_DEFAULT     = 1472;
    localparam int TIMEOUT_CYC_DEFAULT = 1024;
    localparam int BYTES_PER_WORD      = 4;

    // Words leave the FIFO most-significant byte first.
    localparam bit BIG_ENDIAN = 1'b1;

    typedef logic [2:0] upl_state_t;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_FETCH      = 3'd2;
    localparam logic [2:0] ST_WAIT       = 3'd3;
    localparam logic [2:0] ST_SHIFT      = 3'd4;
    localparam logic [2:0] ST_DRAIN      = 3'd5;
    localparam logic [2:0] ST_DRAIN_WAIT = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    // 17-bit arithmetic so that 0xFFFF bytes maps to 16384 words.
    function automatic logic [16:0] word_count(input logic [15:0] len);
        return ({1'b0, len} + 17'd3) >> 2;
    endfunction

endpackage

// File: rtl/upl_word_serializer.sv
// Loads one 32-bit word plus a byte count and presents it as a stream of
// bytes with a valid/ready handshake. Bytes beyond the count are never shown.
module upl_word_serializer
    import eth_upl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [2:0]  i_nbytes,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_accept,
    output logic        o_last
);

    logic [31:0] r_shift;
    logic [2:0]  r_count;

    assign o_valid  = (r_count != 3'd0);
    assign o_data   = BIG_ENDIAN ? r_shift[31:24] : r_shift[7:0];
    assign o_accept = o_valid & i_ready;
    assign o_last   = (r_count == 3'd1);

    // Load a fresh word, or advance one byte per accepted handshake; the
    // shift register is untouched while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 32'h0;
            r_count <= 3'd0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_count <= i_nbytes;
        end else if (o_accept) begin
            r_shift <= BIG_ENDIAN ? {r_shift[23:0], 8'h00} : {8'h00, r_shift[31:8]};
            r_count <= r_count - 3'd1;
        end
    end

endmodule

// File: rtl/upl_fifo_tx_reader.sv
// Read side of the upload FIFO: turns packet requests into word reads and a
// big-endian byte stream for the UDP transmit engine, with one pending slot.
module upl_fifo_tx_reader
    import eth_upl_pkg::*;
#(
    parameter int MAX_LEN     = MAX_LEN_DEFAULT,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_data_en,
    input  logic [15:0] tx_data_len,
    output logic        upl_fifo_rdreq,
    input  logic [31:0] upl_fifo_rddata,
    input  logic        upl_fifo_rdempty,
    output logic        udp_tx_start,
    output logic [15:0] udp_tx_len,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_valid,
    input  logic        udp_tx_ready,
    output logic        send_finish,
    output logic        busy,
    output logic        underrun,
    output logic [7:0]  drop_cnt
);

    upl_state_t  r_state;
    logic        r_en_d1;
    logic        r_en_d2;
    logic [15:0] r_len_cap;
    logic        r_pend_valid;
    logic [15:0] r_pend_len;
    logic [15:0] r_tx_len;
    logic [15:0] r_bytes_left;
    logic [16:0] r_words_left;
    logic [15:0] r_timeout;
    logic        r_underrun;
    logic [7:0]  r_drop_cnt;

    logic        w_event;
    logic        w_event_ok;
    logic        w_req_valid;
    logic [15:0] w_req_len;
    logic [15:0] w_req_clip;
    logic [16:0] w_req_words;
    logic        w_fetching;
    logic        w_fifo_read;
    logic        w_timeout;
    logic        w_ser_load;
    logic [31:0] w_ser_word;
    logic [2:0]  w_ser_nbytes;
    logic        w_ser_valid;
    logic [7:0]  w_ser_data;
    logic        w_ser_accept;
    logic        w_ser_last;

    assign w_event     = r_en_d1 & ~r_en_d2;
    assign w_event_ok  = w_event & (r_len_cap != 16'd0);
    assign w_req_valid = (r_state == ST_IDLE) & (r_pend_valid | w_event_ok);
    assign w_req_len   = r_pend_valid ? r_pend_len : r_len_cap;
    assign w_req_clip  = (w_req_len > 16'(MAX_LEN)) ? 16'(MAX_LEN) : w_req_len;
    assign w_req_words = word_count(w_req_len);

    assign w_fetching  = (r_state == ST_FETCH) | (r_state == ST_DRAIN);
    assign w_fifo_read = w_fetching & ~upl_fifo_rdempty;
    assign w_timeout   = w_fetching & upl_fifo_rdempty & (r_timeout == 16'(TIMEOUT_CYC - 1));

    assign w_ser_load   = (r_state == ST_WAIT) | ((r_state == ST_FETCH) & w_timeout);
    assign w_ser_word   = (r_state == ST_WAIT) ? upl_fifo_rddata : 32'h0;
    assign w_ser_nbytes = (r_bytes_left >= 16'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD)
                                                                : r_bytes_left[2:0];

    upl_word_serializer u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_ser_load),
        .i_word   (w_ser_word),
        .i_nbytes (w_ser_nbytes),
        .i_ready  (udp_tx_ready & (r_state == ST_SHIFT)),
        .o_valid  (w_ser_valid),
        .o_data   (w_ser_data),
        .o_accept (w_ser_accept),
        .o_last   (w_ser_last)
    );

    assign upl_fifo_rdreq = w_fifo_read;
    assign udp_tx_start   = (r_state == ST_START);
    assign udp_tx_len     = r_tx_len;
    assign udp_tx_data    = w_ser_data;
    assign udp_tx_valid   = w_ser_valid & (r_state == ST_SHIFT);
    assign send_finish    = (r_state == ST_DONE);
    assign busy           = (r_state != ST_IDLE);
    assign underrun       = r_underrun;
    assign drop_cnt       = r_drop_cnt;

    // Rising-edge detect on the request strobe; the delay flops come out of
    // reset high so a strobe already high during reset is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d1   <= 1'b1;
            r_en_d2   <= 1'b1;
            r_len_cap <= 16'd0;
        end else begin
            r_en_d1 <= tx_data_en;
            r_en_d2 <= r_en_d1;
            if (tx_data_en & ~r_en_d1) begin
                r_len_cap <= tx_data_len;
            end
        end
    end

    // Single pending slot: IDLE drains it first, a new event refills it,
    // and an event arriving with the slot full is dropped and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_len   <= 16'd0;
            r_drop_cnt   <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            if (r_pend_valid) begin
                r_pend_valid <= w_event_ok;
                if (w_event_ok) begin
                    r_pend_len <= r_len_cap;
                end
            end
        end else if (w_event_ok) begin
            if (!r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_len   <= r_len_cap;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Packet sequencer: fetch a word, stream its bytes, drain any words
    // past the clipped length, then report completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tx_len     <= 16'd0;
            r_bytes_left <= 16'd0;
            r_words_left <= 17'd0;
            r_timeout    <= 16'd0;
            r_underrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_tx_len     <= w_req_clip;
                        r_bytes_left <= w_req_clip;
                        r_words_left <= w_req_words;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_timeout <= 16'd0;
                    r_state   <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_fifo_read) begin
                        r_words_left <= r_words_left - 17'd1;
                        r_timeout    <= 16'd0;
                        r_state      <= ST_WAIT;
                    end else if (w_timeout) begin
                        r_underrun   <= 1'b1;
                        r_words_left <= r_words_left - 17'd1;
                        r_timeout    <= 16'd0;
                        r_state      <= ST_SHIFT;
                    end else begin
                        r_timeout <= r_timeout + 16'd1;
                    end
                end
                ST_WAIT: begin
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_ser_accept) begin
                        r_bytes_left <= r_bytes_left - 16'd1;
                        if (r_bytes_left == 16'd1) begin
                            r_state <= (r_words_left != 17'd0) ? ST_DRAIN : ST_DONE;
                        end else if (w_ser_last) begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_read) begin
                        r_words_left <= r_words_left - 17'd1;
                        r_timeout    <= 16'd0;
                        r_state      <= ST_DRAIN_WAIT;
                    end else if (w_timeout) begin
                        r_underrun <= 1'b1;
                        r_timeout  <= 16'd0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_timeout <= r_timeout + 16'd1;
                    end
                end
                ST_DRAIN_WAIT: begin
                    r_state <= (r_words_left == 17'd0) ? ST_DONE : ST_DRAIN;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
